// File: rtl/sprite_pkg.sv
// Shared constants for the sprite fetch path: sheet geometry, colour width,
// default colour key and heading range.
package sprite_pkg;
  localparam int SPR_W_DEF = 75;
  localparam int SPR_H_DEF = 75;
  localparam int SHEET_W = 600;
  localparam int BANK_OFFSET = 45000;
  localparam int SHEET_PIXELS = 90000;
  localparam int ADDR_W = $clog2(SHEET_PIXELS);
  localparam int RGB_W = 12;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'h0F0;
  localparam int DEG_FULL = 360;

  typedef struct packed {
    logic valid;
    logic hit;
  } trk_t;

  function automatic logic [8:0] norm_deg(input logic [8:0] d);
    return (d >= 9'(DEG_FULL)) ? d - 9'(DEG_FULL) : d;
  endfunction
endpackage

// File: rtl/grid_address_calc.sv
// Sprite-sheet address from heading and sprite-local pixel.
// Ports: degree (0..359), pixel_x/pixel_y (local), addr (0..89999).
import sprite_pkg::*;

module grid_address_calc (
  input  logic [8:0]        degree,
  input  logic [6:0]        pixel_x,
  input  logic [6:0]        pixel_y,
  output logic [ADDR_W-1:0] addr
);
  // 16 headings of 22.5 deg: 8 frames per 600-px row, two banks.
  logic [3:0] frame;

  always_comb begin
    frame = 4'd0;
    for (int i = 1; i < 16; i++)
      if ({degree, 1'b0} >= 10'(i * 45))
        frame = 4'(i);
  end

  assign addr = (frame[3] ? ADDR_W'(BANK_OFFSET) : '0)
              + ADDR_W'(pixel_y) * ADDR_W'(SHEET_W)
              + ADDR_W'(frame[2:0]) * ADDR_W'(SPR_W_DEF)
              + ADDR_W'(pixel_x);
endmodule

// File: rtl/sprite_pixel_pipe.sv
// Per-pixel sprite fetch: window test, ROM addressing, latency-aligned
// colour/hit output. Pose (heading, origin) double-buffered on frame_start.
// Ports: clk, rst, frame_start, degree_in, pos_x/pos_y, h_cnt/v_cnt,
// valid_in, rom_addr, rom_data, pix_valid, pix_hit, pix_rgb.
// Build option: SPRITE_COLORKEY_EN makes KEY_COLOR pixels transparent.
import sprite_pkg::*;

module sprite_pixel_pipe #(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF,
  parameter int ROM_LAT = 1,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [8:0]  degree_in,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid_in,
  output logic [16:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic        pix_valid,
  output logic        pix_hit,
  output logic [11:0] pix_rgb
);
  logic [8:0]  deg_s_q, deg_s_d;
  logic [9:0]  px_s_q, px_s_d;
  logic [9:0]  py_s_q, py_s_d;
  logic        armed_q, armed_d;
  logic [16:0] rom_addr_q, rom_addr_d;
  trk_t [ROM_LAT:0] trk_q, trk_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_hit_q, pix_hit_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;

  logic        in_win;
  logic        take;
  logic        key_ok;
  logic [6:0]  pixel_x;
  logic [6:0]  pixel_y;
  logic [16:0] calc_addr;

  // 11-bit compare so a sprite near the right/bottom edge clips, never wraps.
  assign in_win = ({1'b0, h_cnt} >= {1'b0, px_s_q})
               && ({1'b0, h_cnt} < {1'b0, px_s_q} + 11'(SPR_W))
               && ({1'b0, v_cnt} >= {1'b0, py_s_q})
               && ({1'b0, v_cnt} < {1'b0, py_s_q} + 11'(SPR_H));

  assign pixel_x = h_cnt[6:0] - px_s_q[6:0];
  assign pixel_y = v_cnt[6:0] - py_s_q[6:0];
  assign take = valid_in && in_win && armed_q;

  grid_address_calc u_calc (
    .degree  (deg_s_q),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .addr    (calc_addr)
  );

`ifdef SPRITE_COLORKEY_EN
  assign key_ok = (rom_data != KEY_COLOR);
`else
  assign key_ok = 1'b1;
`endif

  always_comb begin
    deg_s_d = deg_s_q;
    px_s_d = px_s_q;
    py_s_d = py_s_q;
    armed_d = armed_q;
    if (frame_start) begin
      deg_s_d = norm_deg(degree_in);
      px_s_d = pos_x;
      py_s_d = pos_y;
      armed_d = 1'b1;
    end
    rom_addr_d = take ? calc_addr : 17'd0;
    trk_d = {trk_q[ROM_LAT-1:0], trk_t'{valid: valid_in, hit: take}};
    pix_valid_d = trk_q[ROM_LAT].valid;
    pix_hit_d = trk_q[ROM_LAT].hit && key_ok;
    pix_rgb_d = pix_hit_d ? rom_data : 12'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deg_s_q <= '0;
      px_s_q <= '0;
      py_s_q <= '0;
      armed_q <= 1'b0;
      rom_addr_q <= '0;
      trk_q <= '0;
      pix_valid_q <= 1'b0;
      pix_hit_q <= 1'b0;
      pix_rgb_q <= '0;
    end else begin
      deg_s_q <= deg_s_d;
      px_s_q <= px_s_d;
      py_s_q <= py_s_d;
      armed_q <= armed_d;
      rom_addr_q <= rom_addr_d;
      trk_q <= trk_d;
      pix_valid_q <= pix_valid_d;
      pix_hit_q <= pix_hit_d;
      pix_rgb_q <= pix_rgb_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_hit = pix_hit_q;
  assign pix_rgb = pix_rgb_q;
endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Scoreboard bench for sprite_pixel_pipe with a registered-ROM model.
// Honours SPRITE_COLORKEY_EN the same way the design does.
module tb_sprite_pixel_pipe;
  localparam int ROM_LAT = 1;
  localparam int LAT = ROM_LAT + 2;
  localparam logic [11:0] KEY = 12'h0F0;
`ifdef SPRITE_COLORKEY_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [8:0]  degree_in;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid_in;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  logic        pix_valid;
  logic        pix_hit;
  logic [11:0] pix_rgb;

  sprite_pixel_pipe #(.ROM_LAT(ROM_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .degree_in   (degree_in),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .valid_in    (valid_in),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_valid   (pix_valid),
    .pix_hit     (pix_hit),
    .pix_rgb     (pix_rgb)
  );

  typedef struct {
    logic [16:0] addr;
    logic        hit;
    logic [11:0] rgb;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int nid = 0;
  bit ff_mode = 1'b0;
  logic [16:0] hist0 = '0;
  logic [16:0] hist1 = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Address 75 holds the key colour; everything else is a scrambled address.
  function automatic logic [11:0] rom_f(input logic [16:0] a);
    if (a == 17'd75) return KEY;
    if (ff_mode) return 12'hFFF;
    return a[11:0] ^ 12'h5A3;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  always @(negedge clk) begin
    logic [16:0] a_then;
    exp_t e;
    a_then = hist1;
    hist1 = hist0;
    hist0 = rom_addr;
    if (!rst && pix_valid) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: pix_valid=1 required 0 (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        if (pix_hit === e.hit && pix_rgb === e.rgb && a_then === e.addr
            && (cyc - e.cyc) == LAT)
          passes++;
        else
          $display({"FAIL sample%0d: hit=%0b rgb=%h addr=%0d lat=%0d ",
                    "required hit=%0b rgb=%h addr=%0d lat=%0d"},
                   e.id, pix_hit, pix_rgb, a_then, cyc - e.cyc,
                   e.hit, e.rgb, e.addr, LAT);
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if (pix_valid === 1'b0 && pix_hit === 1'b0 && pix_rgb === 12'd0
        && rom_addr === 17'd0)
      passes++;
    else
      $display("FAIL %s: valid=%0b hit=%0b rgb=%h addr=%0d required all 0",
               nm, pix_valid, pix_hit, pix_rgb, rom_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [8:0] d, input logic [9:0] x, y);
    degree_in = d;
    pos_x = x;
    pos_y = y;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic sample(input logic [9:0] h, v, input logic [16:0] a,
                        input logic w, input logic fs = 1'b0);
    exp_t e;
    h_cnt = h;
    v_cnt = v;
    valid_in = 1'b1;
    frame_start = fs;
    e.addr = a;
    e.hit = w && !(CK && rom_f(a) == KEY);
    e.rgb = e.hit ? rom_f(a) : 12'd0;
    e.cyc = cyc;
    e.id = nid++;
    sb.push_back(e);
    tick();
    valid_in = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    degree_in = '0;
    pos_x = '0;
    pos_y = '0;
    h_cnt = '0;
    v_cnt = '0;
    valid_in = 1'b0;
    idle(3);
    check_zero("reset_state");
    rst = 1'b0;

    // Unarmed sweep: never a hit, pix_valid tracks valid_in.
    ff_mode = 1'b1;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 640; x++)
        sample(10'(x), 10'(y), 17'd0, 1'b0);
      idle(16);
    end
    idle(4);
    ff_mode = 1'b0;
    idle(3);

    // Heading 0 at (100,50): corners and edges.
    pulse(9'd0, 10'd100, 10'd50);
    sample(10'd100, 10'd50, 17'd0, 1'b1);
    sample(10'd174, 10'd124, 17'd44474, 1'b1);
    sample(10'd175, 10'd124, 17'd0, 1'b0);
    sample(10'd99, 10'd50, 17'd0, 1'b0);
    sample(10'd100, 10'd49, 17'd0, 1'b0);
    sample(10'd174, 10'd125, 17'd0, 1'b0);
    sample(10'd101, 10'd51, 17'd601, 1'b1);
    idle(2);

    // Bank and frame selection; 400 folds to 40 and hits the key pixel.
    pulse(9'd200, 10'd100, 10'd50);
    sample(10'd100, 10'd50, 17'd45000, 1'b1);
    pulse(9'd359, 10'd100, 10'd50);
    sample(10'd100, 10'd50, 17'd45525, 1'b1);
    sample(10'd101, 10'd51, 17'd46126, 1'b1);
    pulse(9'd400, 10'd100, 10'd50);
    sample(10'd100, 10'd50, 17'd75, 1'b1);
    idle(2);

    // Pose changes need a pulse; a coincident pulse applies next sample.
    pulse(9'd0, 10'd100, 10'd50);
    degree_in = 9'd200;
    pos_x = 10'd300;
    sample(10'd100, 10'd50, 17'd0, 1'b1);
    pos_x = 10'd100;
    sample(10'd100, 10'd50, 17'd0, 1'b1, 1'b1);
    sample(10'd100, 10'd50, 17'd45000, 1'b1);
    idle(2);

    // Right-edge clip, then reset with samples in flight.
    pulse(9'd0, 10'd600, 10'd0);
    sample(10'd5, 10'd0, 17'd0, 1'b0);
    sample(10'd639, 10'd0, 17'd39, 1'b1);
    idle(5);
    for (int i = 0; i < 4; i++)
      sample(10'(600 + i), 10'd0, 17'(i), 1'b1);
    rst = 1'b1;
    sb.delete();
    #1;
    check_zero("reset_flush");
    idle(2);
    rst = 1'b0;
    idle(6);
    sample(10'd10, 10'd10, 17'd0, 1'b0);
    idle(8);

    checks++;
    if (sb.size() == 0)
      passes++;
    else
      $display("FAIL drain: %0d samples outstanding, required 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
